// File: rtl/mbank_pp_sram.sv
// Multi-channel single-port SRAM with optional ping-pong paging and 1/2-cycle read latency.
// Each channel is an independent instance; the shared page register steers writes and reads.

module mbank_pp_sram_ch #(
  parameter int DW       = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int PINGPONG = 1,
  parameter int RD_LAT   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_d,
  input  logic          i_page,
  output logic [DW-1:0] o_q,
  output logic          o_qv
);
  localparam int NPG = (PINGPONG != 0) ? 2 : 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]              r_mem [NPG][DEPTH];
  logic [RD_LAT:1]            r_vld;
  logic [RD_LAT:1][DW-1:0]    r_qp;

  logic          w_wp, w_rp, w_inr, w_rd;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_rdata;

  assign w_wp    = (PINGPONG != 0) ? i_page  : 1'b0;
  assign w_rp    = (PINGPONG != 0) ? ~i_page : 1'b0;
  assign w_inr   = (32'(i_addr) < DEPTH);
  assign w_idx   = i_addr[IW-1:0];
  // Write wins a same-channel collision; the read is simply not issued.
  assign w_rd    = i_re & ~i_we;
  assign w_rdata = w_inr ? r_mem[w_rp][w_idx] : '0;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_we && w_inr)
      r_mem[w_wp][w_idx] <= i_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      r_qp  <= '0;
    end else begin
      r_vld[1] <= w_rd;
      if (w_rd) r_qp[1] <= w_rdata;
      // Data stages only load on a valid result so Q holds between reads.
      for (int s = 2; s <= RD_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_qp[s] <= r_qp[s-1];
      end
    end
  end

  assign o_q  = r_qp[RD_LAT];
  assign o_qv = r_vld[RD_LAT];
endmodule

module mbank_pp_sram #(
  parameter int NCH      = 2,
  parameter int DW       = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int PINGPONG = 1,
  parameter int RD_LAT   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_we,
  input  logic [NCH-1:0]    i_re,
  input  logic [NCH*AW-1:0] i_addr,
  input  logic [NCH*DW-1:0] i_d,
  input  logic              i_swap,
  output logic [NCH*DW-1:0] o_q,
  output logic [NCH-1:0]    o_qv,
  output logic              o_page
);
  logic r_page;

  always_ff @(posedge i_clk) begin
    if (i_rst)                          r_page <= 1'b0;
    else if (i_swap && PINGPONG != 0)   r_page <= ~r_page;
  end

  assign o_page = r_page;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mbank_pp_sram_ch #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW), .PINGPONG(PINGPONG), .RD_LAT(RD_LAT)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_we   (i_we[g]),
      .i_re   (i_re[g]),
      .i_addr (i_addr[g*AW +: AW]),
      .i_d    (i_d[g*DW +: DW]),
      .i_page (r_page),
      .o_q    (o_q[g*DW +: DW]),
      .o_qv   (o_qv[g])
    );
  end
endmodule

// File: tb/tb_mbank_pp_sram.sv
// Bench for mbank_pp_sram: three shared-stimulus instances (RD_LAT=1, RD_LAT=2, DEPTH=24)
// checked every cycle against a page/memory model and a per-channel expected-read queue.

module tb_mbank_pp_sram;
  localparam int ND = 3;
  localparam int LAT [ND] = '{1, 2, 1};
  localparam int DEP [ND] = '{32, 32, 24};

  typedef struct { int due; logic [63:0] data; } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   we, re;
  logic [9:0]   addr;
  logic [127:0] din;
  logic         swap;

  logic [127:0] q_o  [ND];
  logic [1:0]   qv_o [ND];
  logic         pg_o [ND];

  logic [63:0]  mdl  [ND][2][2][32];
  exp_t         sbq  [ND*2][$];
  logic [63:0]  last [ND*2];
  logic         page;
  int           cyc, n_chk, n_fail;

  always #5 clk = ~clk;

  mbank_pp_sram #(.NCH(2), .DW(64), .DEPTH(32), .AW(5), .PINGPONG(1), .RD_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_re(re), .i_addr(addr), .i_d(din), .i_swap(swap),
    .o_q(q_o[0]), .o_qv(qv_o[0]), .o_page(pg_o[0]));
  mbank_pp_sram #(.NCH(2), .DW(64), .DEPTH(32), .AW(5), .PINGPONG(1), .RD_LAT(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_re(re), .i_addr(addr), .i_d(din), .i_swap(swap),
    .o_q(q_o[1]), .o_qv(qv_o[1]), .o_page(pg_o[1]));
  mbank_pp_sram #(.NCH(2), .DW(64), .DEPTH(24), .AW(5), .PINGPONG(1), .RD_LAT(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_re(re), .i_addr(addr), .i_d(din), .i_swap(swap),
    .o_q(q_o[2]), .o_qv(qv_o[2]), .o_page(pg_o[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("page d%0d", d), 64'(pg_o[d]), 64'(page));
      for (int c = 0; c < 2; c++) begin
        int   i;
        logic ev;
        i = d*2 + c;
        while (sbq[i].size() > 0 && sbq[i][0].due < cyc) void'(sbq[i].pop_front());
        ev = (sbq[i].size() > 0) && (sbq[i][0].due == cyc);
        chk($sformatf("qv d%0d c%0d cyc%0d", d, c, cyc), 64'(qv_o[d][c]), 64'(ev));
        if (ev) begin
          last[i] = sbq[i][0].data;
          void'(sbq[i].pop_front());
        end
        chk($sformatf("q d%0d c%0d cyc%0d", d, c, cyc), q_o[d][c*64 +: 64], last[i]);
      end
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check outputs on the falling edge.
  task automatic step(input logic r, input logic [1:0] w, input logic [1:0] rd,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [63:0] wd0, input logic [63:0] wd1, input logic sw);
    rst = r; we = w; re = rd; addr = {a1, a0}; din = {wd1, wd0}; swap = sw;
    @(posedge clk);
    cyc++;
    if (r) begin
      page = 1'b0;
      for (int i = 0; i < ND*2; i++) begin
        sbq[i].delete();
        last[i] = '0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0]  a;
          logic [63:0] v;
          exp_t        e;
          a = c ? a1 : a0;
          v = c ? wd1 : wd0;
          if (w[c]) begin
            if (int'(a) < DEP[d]) mdl[d][c][page][a] = v;
          end else if (rd[c]) begin
            e.due  = cyc + LAT[d] - 1;
            e.data = (int'(a) < DEP[d]) ? mdl[d][c][~page][a] : 64'd0;
            sbq[d*2+c].push_back(e);
          end
        end
      end
      if (sw) page = ~page;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] r0, r1;
    cyc = 0; n_chk = 0; n_fail = 0; page = 1'b0;
    rst = 1'b1; we = '0; re = '0; addr = '0; din = '0; swap = 1'b0;
    for (int i = 0; i < ND*2; i++) last[i] = '0;
    @(negedge clk);

    step(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0);

    // Fill both pages of both channels with random data.
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 32; a++) begin
        r0 = {$urandom, $urandom};
        r1 = {$urandom, $urandom};
        step(1'b0, 2'b11, 2'b00, 5'(a), 5'(a), r0, r1, a == 31);
      end

    // Reset held two cycles with everything asserted must leave memory untouched.
    step(1'b1, 2'b11, 2'b11, 5'd3, 5'd5, '1, '1, 1'b1);
    step(1'b1, 2'b11, 2'b11, 5'd3, 5'd5, '1, '1, 1'b1);
    chk("rst_q", q_o[1][63:0], 64'd0);
    chk("rst_qv", 64'(qv_o[1]), 64'd0);
    chk("rst_page", 64'(pg_o[0]), 64'd0);
    step(1'b0, 2'b00, 2'b11, 5'd3, 5'd5, 64'd0, 64'd0, 1'b0);
    idle(2);

    // Ping-pong: pre-swap read sees page 1, post-swap read sees the new write.
    step(1'b0, 2'b01, 2'b00, 5'd3, 5'd0, 64'hA5, 64'd0, 1'b0);
    step(1'b0, 2'b00, 2'b01, 5'd3, 5'd0, 64'd0, 64'd0, 1'b0);
    step(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1);
    step(1'b0, 2'b00, 2'b01, 5'd3, 5'd0, 64'd0, 64'd0, 1'b0);
    chk("pp_a5", q_o[0][63:0], 64'hA5);
    idle(2);

    // Collision on ch1 while ch0 reads.
    step(1'b0, 2'b10, 2'b11, 5'd7, 5'd7, 64'd0, 64'h1234, 1'b0);
    idle(2);
    step(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b1);
    step(1'b0, 2'b00, 2'b10, 5'd0, 5'd7, 64'd0, 64'd0, 1'b0);
    chk("coll_1234", q_o[0][127:64], 64'h1234);
    idle(2);

    // Streaming 32 back-to-back reads (DEPTH=24 instance returns zero above 23).
    for (int a = 0; a < 32; a++) step(1'b0, 2'b00, 2'b01, 5'(a), 5'd0, 64'd0, 64'd0, 1'b0);
    idle(3);

    // Read issued together with SWAP.
    step(1'b0, 2'b00, 2'b01, 5'd4, 5'd0, 64'd0, 64'd0, 1'b1);
    chk("swap_page", 64'(pg_o[1]), 64'(page));
    idle(3);

    // Reset one cycle after a read discards the RD_LAT=2 result.
    step(1'b0, 2'b00, 2'b01, 5'd5, 5'd0, 64'd0, 64'd0, 1'b0);
    step(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0);
    chk("rstrd_qv", 64'(qv_o[1][0]), 64'd0);
    chk("rstrd_q", q_o[1][63:0], 64'd0);
    idle(2);

    // Out-of-range on the DEPTH=24 instance.
    step(1'b0, 2'b10, 2'b00, 5'd0, 5'd30, 64'd0, 64'hDEAD, 1'b1);
    step(1'b0, 2'b00, 2'b10, 5'd0, 5'd30, 64'd0, 64'd0, 1'b0);
    chk("oor_qv", 64'(qv_o[2][1]), 64'd1);
    chk("oor_q", q_o[2][127:64], 64'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
